// File: rtl/matrix_multiply_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : matrix_multiply_ctrl
// Purpose  : Time-multiplexed C = A*B sequencer over row-major operand buffers
//            with a single multiply-accumulate. Define MATMUL_SATURATE_EN to
//            saturate C elements instead of truncating them.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_multiply_ctrl #(
    parameter int MAT_SIZE = 2,
    parameter int DAT_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [9:0]          a_addr,
    output logic [9:0]          b_addr,
    input  logic [DAT_SIZE-1:0] a_data,
    input  logic [DAT_SIZE-1:0] b_data,
    output logic                c_we,
    output logic [9:0]          c_addr,
    output logic [DAT_SIZE-1:0] c_data
);

    localparam int EXT_W = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;
    localparam int ACC_W = 2 * DAT_SIZE + EXT_W;
    localparam logic [4:0] c_IDX_LAST = 5'(MAT_SIZE - 1);
    localparam logic [9:0] c_N        = 10'(MAT_SIZE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_LAST  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [4:0]            r_i, r_j, r_k;
    logic [4:0]            w_i_nx, w_j_nx, w_k_nx;
    logic [ACC_W-1:0]      r_acc;
    logic [ACC_W-1:0]      w_acc_sum;
    logic [2*DAT_SIZE-1:0] w_prod;
    logic [DAT_SIZE-1:0]   w_result;
    logic                  r_mac_en;

    logic                  r_busy, r_done, r_rd_en, r_c_we;
    logic [9:0]            r_a_addr, r_b_addr, r_c_addr;
    logic [DAT_SIZE-1:0]   r_c_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nx;
            r_i     <= w_i_nx;
            r_j     <= w_j_nx;
            r_k     <= w_k_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_i_nx     = r_i;
        w_j_nx     = r_j;
        w_k_nx     = r_k;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_RUN;
                    w_i_nx     = '0;
                    w_j_nx     = '0;
                    w_k_nx     = '0;
                end
            end
            S_RUN: begin
                if (r_k == c_IDX_LAST) begin
                    w_state_nx = S_LAST;
                    w_k_nx     = '0;
                end else begin
                    w_k_nx = r_k + 5'd1;
                end
            end
            S_LAST: w_state_nx = S_WRITE;
            S_WRITE: begin
                w_k_nx = '0;
                if (r_j == c_IDX_LAST) begin
                    w_j_nx = '0;
                    if (r_i == c_IDX_LAST) begin
                        w_i_nx     = '0;
                        w_state_nx = S_DONE;
                    end else begin
                        w_i_nx     = r_i + 5'd1;
                        w_state_nx = S_RUN;
                    end
                end else begin
                    w_j_nx     = r_j + 5'd1;
                    w_state_nx = S_RUN;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Operand data arrives one cycle after rd_en, so the MAC enable is rd_en delayed.
    assign w_prod    = a_data * b_data;
    assign w_acc_sum = r_acc + (r_mac_en ? {{EXT_W{1'b0}}, w_prod} : {ACC_W{1'b0}});

`ifdef MATMUL_SATURATE_EN
    assign w_result = (|w_acc_sum[ACC_W-1:DAT_SIZE]) ? {DAT_SIZE{1'b1}}
                                                     : w_acc_sum[DAT_SIZE-1:0];
`else
    assign w_result = w_acc_sum[DAT_SIZE-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mac_en <= 1'b0;
        end else begin
            r_mac_en <= r_rd_en;
            if (r_state == S_RUN || r_state == S_LAST) begin
                r_acc <= w_acc_sum;
            end else begin
                r_acc <= '0;
            end
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rd_en  <= 1'b0;
            r_c_we   <= 1'b0;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_c_addr <= '0;
            r_c_data <= '0;
        end else begin
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= (w_state_nx == S_DONE);
            r_rd_en <= (w_state_nx == S_RUN);
            r_c_we  <= (w_state_nx == S_WRITE);
            if (w_state_nx == S_RUN) begin
                r_a_addr <= {5'd0, w_i_nx} * c_N + {5'd0, w_k_nx};
                r_b_addr <= {5'd0, w_k_nx} * c_N + {5'd0, w_j_nx};
            end
            if (w_state_nx == S_WRITE) begin
                r_c_addr <= {5'd0, r_i} * c_N + {5'd0, r_j};
                r_c_data <= w_result;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign rd_en  = r_rd_en;
    assign a_addr = r_a_addr;
    assign b_addr = r_b_addr;
    assign c_we   = r_c_we;
    assign c_addr = r_c_addr;
    assign c_data = r_c_data;

endmodule
`default_nettype wire

// File: doc/matrix_multiply_ctrl.md
# matrix_multiply_ctrl

Sequencer for the matrix-multiply accelerator. It computes C = A·B on unsigned square matrices. Operands are read element-by-element from the A and B operand buffers (1024 entries, row-major), passed through a single multiply-accumulate, and each C element is written to the result buffer. It sits between the bus-side start/done register interface and the operand/result buffers, replacing the flat whole-matrix datapath with a time-multiplexed one.

## Interface
- mat_size, default 2: matrix dimension N; legal 1..32 (N² ≤ 1024).
- dat_size, default 8: element width in bits for A, B and C.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  launch request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last C element has been written.
- rd_en  out  1  read strobe to both operand buffers.
- a_addr  out  10  A index, i·N+k.
- b_addr  out  10  B index, k·N+j.
- a_data  in  dat_size  A element, valid the cycle after rd_en.
- b_data  in  dat_size  B element, valid the cycle after rd_en.
- c_we  out  1  result-buffer write strobe.
- c_addr  out  10  C index, i·N+j.
- c_data  out  dat_size  C element value.

## Operation
- FSM states: IDLE, RUN, LAST, WRITE, DONE.
- IDLE:
  - start=1 → RUN with i=j=k=0 and the accumulator cleared.
  - start=0 → stay in IDLE.
- RUN:
  - rd_en=1, with a_addr and b_addr driven from the current (i,j,k).
  - k increments each cycle.
  - After the cycle with k=N−1 → LAST.
- Accumulate: in the cycle after each rd_en, acc += a_data·b_data.
  - acc is unsigned, 2·dat_size+clog2(N) bits (minimum 1 extra bit), and never wraps.
- LAST: rd_en=0. The final product of the element is accumulated. → WRITE.
- WRITE:
  - c_we=1, c_addr=i·N+j, c_data=result(acc).
  - acc is cleared and k=0.
  - Advance j; when j wraps from N−1 to 0, advance i.
  - If (i,j) was (N−1,N−1) → DONE; else → RUN.
- DONE: done=1 for exactly one cycle, busy=1. → IDLE.
- start is ignored in RUN, LAST, WRITE and DONE; a pending start is not queued.
- start held high continuously: a new run begins from the IDLE cycle that follows DONE.
- Reset, including mid-operation:
  - FSM → IDLE; i, j, k and acc → 0.
  - The partial result is discarded and no further c_we is issued.
  - Result-buffer contents already written are not restored.

## Timing
- Reset values: busy=0, done=0, rd_en=0, c_we=0, a_addr=b_addr=c_addr=0, c_data=0.
- Every output is registered; none depends combinationally on an input.
- Cycle numbering: the edge that samples start is edge 0, and cycle 1 is the first RUN cycle.
- Each C element occupies N+2 cycles: N RUN, 1 LAST, 1 WRITE.
- The write of element (i,j) is in cycle (i·N+j+1)·(N+2).
- done is high in cycle N²·(N+2)+1; the FSM returns to IDLE in the following cycle.
- Operand buffers must have exactly 1-cycle read latency.
- c_data is valid only while c_we=1; otherwise it holds its last value.

## Configuration
- MATMUL_SATURATE_EN:
  - Defined: result(acc) = 2^dat_size−1 if acc ≥ 2^dat_size, else acc.
  - Undefined: result(acc) = acc[dat_size-1:0], i.e. truncation modulo 2^dat_size.
- Nothing else changes; latency is identical in both builds.

## Test plan
- Identity: N=2, A=[1,0;0,1], B=[1,2;3,4].
  - Writes (addr,data) (0,1), (1,2), (2,3), (3,4) in cycles 4, 8, 12, 16.
  - done is high only in cycle 17; busy is high in cycles 1–17.
- General product: N=2, A=[1,2;3,4], B=[5,6;7,8] → C=[19,22;43,50]. a_addr/b_addr sequence for element (0,0) is (0,0),(1,2).
- Overflow: N=2, all A and B elements =200, so acc=80000 for every element.
  - Without the macro: every c_data=128.
  - With MATMUL_SATURATE_EN: every c_data=255.
- Start while busy: pulse start again in cycle 6 → ignored; exactly 4 writes and one done pulse.
- Reset mid-run: rst=1 in cycle 9.
  - From cycle 10: all outputs 0; no c_we until a new start.
  - A fresh start then yields the full correct result with done in cycle 17.
- N=1, A=[7], B=[9]: c_we in cycle 3 with c_addr=0 and c_data=63; done in cycle 4.
